// File: rtl/lat_mem_pkg.sv
// Shared definitions for the multi-cycle MEM-stage data memory:
// request opcodes, controller state encoding and the parameter sanity check.
package lat_mem_pkg;

  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_RESP = 3'd3,
    ST_WR_RESP = 3'd4
  } mem_state_e;

  // Both latencies must be at least one cycle and the data word must be whole bytes.
  function automatic bit lat_params_ok(input int rd_lat, input int wr_lat, input int data_w);
    return (rd_lat >= 32'sd1) && (wr_lat >= 32'sd1) &&
           (data_w > 32'sd0) && ((data_w % 32'sd8) == 32'sd0);
  endfunction

endpackage

// File: rtl/lat_mem_array.sv
// Single-port word array with a registered, held read port and a byte-enabled
// synchronous write. Word 0 powers up as 1, all other words as 0; reset only
// clears the read register, never the stored contents.
module lat_mem_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_r [DEPTH] = '{0: {{(DATA_W-1){1'b0}}, 1'b1}, default: '0};
  logic [DATA_W-1:0] rdata_r;

  // Byte-lane write: only lanes whose strobe is set are replaced.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) begin
          mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read that holds its value until the next read or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= '0;
    end else if (rd_en) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/lat_mem_param_chk.sv
// Elaboration-time guard: refuses to build the memory with a zero latency
// or a data width that is not a whole number of bytes.
module lat_mem_param_chk
  import lat_mem_pkg::*;
#(
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 3,
  parameter int DATA_W = 32
) ();

  generate
    if (!lat_params_ok(RD_LAT, WR_LAT, DATA_W)) begin : g_bad_params
      $fatal(1, "lat_data_mem: RD_LAT and WR_LAT must be >= 1 and DATA_W a multiple of 8");
    end
  endgenerate

endmodule

// File: rtl/lat_data_mem.sv
// MEM-stage data memory with configurable read/write latency behind a
// request/busy handshake. A request is taken in IDLE or in a one-cycle
// response state (back-to-back issue); while waiting, new requests are ignored.
module lat_data_mem
  import lat_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mem_op,
  input  logic [31:0]           addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rvalid,
  output logic                  done,
  output logic                  busy
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);

  mem_state_e          state_r;
  mem_state_e          state_n_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_n_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [STRB_W-1:0]   wstrb_r;
  logic                rvalid_r;
  logic                done_r;
  logic                busy_r;

  logic                can_accept_s;
  logic                accept_s;
  logic                arr_rd_en_s;
  logic                arr_wr_en_s;
  logic [ADDR_W-1:0]   arr_addr_s;
  logic [DATA_W-1:0]   arr_wdata_s;
  logic [STRB_W-1:0]   arr_wstrb_s;

  // Upper address bits are discarded so addresses wrap onto the array.
  logic                unused_addr_s;
  assign unused_addr_s = ^addr[31:ADDR_W];

  lat_mem_param_chk #(
    .RD_LAT (RD_LAT),
    .WR_LAT (WR_LAT),
    .DATA_W (DATA_W)
  ) u_param_chk ();

  // Next-state and latency counter: accept, count down in WAIT, one-cycle RESP.
  always_comb begin
    state_n_s    = state_r;
    cnt_n_s      = cnt_r;
    accept_s     = 1'b0;
    can_accept_s = (state_r == ST_IDLE) || (state_r == ST_RD_RESP) ||
                   (state_r == ST_WR_RESP);
    if (rst) begin
      state_n_s = ST_IDLE;
      cnt_n_s   = '0;
    end else begin
      accept_s = can_accept_s && (mem_op != 2'b00);
      if (accept_s) begin
        if ((mem_op & OP_WRITE) != 2'b00) begin
          // A combined read+write request is treated as a write only.
          state_n_s = (WR_LAT == 1) ? ST_WR_RESP : ST_WR_WAIT;
          cnt_n_s   = WR_LOAD;
        end else begin
          state_n_s = (RD_LAT == 1) ? ST_RD_RESP : ST_RD_WAIT;
          cnt_n_s   = RD_LOAD;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_n_s = ST_IDLE;
          end
          ST_RD_WAIT: begin
            if (cnt_r == CNT_ONE) begin
              state_n_s = ST_RD_RESP;
            end else begin
              cnt_n_s = cnt_r - CNT_ONE;
            end
          end
          ST_WR_WAIT: begin
            if (cnt_r == CNT_ONE) begin
              state_n_s = ST_WR_RESP;
            end else begin
              cnt_n_s = cnt_r - CNT_ONE;
            end
          end
          ST_RD_RESP: begin
            state_n_s = ST_IDLE;
          end
          ST_WR_RESP: begin
            state_n_s = ST_IDLE;
          end
          default: begin
            state_n_s = ST_IDLE;
          end
        endcase
      end
    end
  end

  // Array strobes fire on entry to a RESP state; a same-edge accept
  // (latency 1) uses the live request, otherwise the latched one.
  always_comb begin
    arr_rd_en_s = (state_n_s == ST_RD_RESP);
    arr_wr_en_s = (state_n_s == ST_WR_RESP);
    if (accept_s) begin
      arr_addr_s  = addr[ADDR_W-1:0];
      arr_wdata_s = wdata;
      arr_wstrb_s = wstrb;
    end else begin
      arr_addr_s  = addr_r;
      arr_wdata_s = wdata_r;
      arr_wstrb_s = wstrb_r;
    end
  end

  // State, counter, request latch and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      addr_r   <= '0;
      wdata_r  <= '0;
      wstrb_r  <= '0;
      rvalid_r <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_n_s;
      cnt_r    <= cnt_n_s;
      if (accept_s) begin
        addr_r  <= addr[ADDR_W-1:0];
        wdata_r <= wdata;
        wstrb_r <= wstrb;
      end
      rvalid_r <= (state_n_s == ST_RD_RESP);
      done_r   <= (state_n_s == ST_WR_RESP);
      busy_r   <= (state_n_s == ST_RD_WAIT) || (state_n_s == ST_WR_WAIT);
    end
  end

  lat_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .rd_en (arr_rd_en_s),
    .wr_en (arr_wr_en_s),
    .addr  (arr_addr_s),
    .wdata (arr_wdata_s),
    .wstrb (arr_wstrb_s),
    .rdata (rdata)
  );

  assign rvalid = rvalid_r;
  assign done   = done_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_lat_data_mem.sv
// Directed bench for lat_data_mem: a default-latency instance (4/3) and a
// single-cycle instance (1/1). Expected read data, response cycles and busy
// windows are queued when a request is driven and checked every cycle.
module tb_lat_data_mem;

  localparam int RL0 = 4;
  localparam int WL0 = 3;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rd_exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  mem_op0, mem_op1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [3:0]  wstrb0, wstrb1;
  logic [31:0] rdata0, rdata1;
  logic        rvalid0, rvalid1;
  logic        done0, done1;
  logic        busy0, busy1;

  int      checks;
  int      errors;
  int      cyc;
  rd_exp_t rq0[$];
  rd_exp_t rq1[$];
  int      dq0[$];
  int      dq1[$];
  int      bz0_lo, bz0_hi;

  lat_data_mem #(.DATA_W(32), .ADDR_W(10), .RD_LAT(RL0), .WR_LAT(WL0)) dut0 (
    .clk(clk), .rst(rst), .mem_op(mem_op0), .addr(addr0), .wdata(wdata0),
    .wstrb(wstrb0), .rdata(rdata0), .rvalid(rvalid0), .done(done0), .busy(busy0)
  );

  lat_data_mem #(.DATA_W(32), .ADDR_W(10), .RD_LAT(1), .WR_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .mem_op(mem_op1), .addr(addr1), .wdata(wdata1),
    .wstrb(wstrb1), .rdata(rdata1), .rvalid(rvalid1), .done(done1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock: advance, then check every strobe of both instances.
  task automatic tick();
    logic ev;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    ev = (rq0.size() > 0) && (rq0[0].cyc == cyc);
    chk("rvalid0", {31'b0, rvalid0}, {31'b0, ev});
    if (ev) begin
      chk("rdata0", rdata0, rq0[0].data);
      rq0.delete(0);
    end
    ev = (dq0.size() > 0) && (dq0[0] == cyc);
    chk("done0", {31'b0, done0}, {31'b0, ev});
    if (ev) dq0.delete(0);
    chk("busy0", {31'b0, busy0}, {31'b0, (cyc >= bz0_lo) && (cyc <= bz0_hi)});
    ev = (rq1.size() > 0) && (rq1[0].cyc == cyc);
    chk("rvalid1", {31'b0, rvalid1}, {31'b0, ev});
    if (ev) begin
      chk("rdata1", rdata1, rq1[0].data);
      rq1.delete(0);
    end
    ev = (dq1.size() > 0) && (dq1[0] == cyc);
    chk("done1", {31'b0, done1}, {31'b0, ev});
    if (ev) dq1.delete(0);
    chk("busy1", {31'b0, busy1}, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drv0(input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    mem_op0 = op; addr0 = a; wdata0 = d; wstrb0 = s;
  endtask

  task automatic drv1(input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    mem_op1 = op; addr1 = a; wdata1 = d; wstrb1 = s;
  endtask

  // Expectations for a request driven on dut0 in the current cycle.
  task automatic exp_rd0(input logic [31:0] d);
    rq0.push_back('{d, cyc + RL0});
    bz0_lo = cyc + 1;
    bz0_hi = cyc + RL0 - 1;
  endtask

  task automatic exp_wr0();
    dq0.push_back(cyc + WL0);
    bz0_lo = cyc + 1;
    bz0_hi = cyc + WL0 - 1;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    bz0_lo = 1; bz0_hi = 0;
    rst = 1'b1;
    drv0(2'b00, 32'h0, 32'h0, 4'h0);
    drv1(2'b00, 32'h0, 32'h0, 4'h0);

    // Reset, with a read presented during the last reset cycle.
    tick();
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    drv0(2'b01, 32'h0, 32'h0, 4'h0);
    tick();
    chk("rst_rdata0b", rdata0, 32'h0);
    rst = 1'b0;
    drv0(2'b00, 32'h0, 32'h0, 4'h0);
    idle(3);

    // Default-latency read of word 0 (initial value 1), then hold check.
    drv0(2'b01, 32'h0, 32'h0, 4'h0); exp_rd0(32'h1); tick();
    drv0(2'b00, 32'h0, 32'h0, 4'h0); idle(RL0 - 1);
    tick();
    chk("rdata_hold", rdata0, 32'h1);

    // Byte-enabled write, read issued in the done cycle.
    drv0(2'b10, 32'd5, 32'hAABBCCDD, 4'b0101); exp_wr0(); tick();
    drv0(2'b00, 32'h0, 32'h0, 4'h0); idle(WL0 - 1);
    drv0(2'b01, 32'd5, 32'h0, 4'h0); exp_rd0(32'h00BB00DD); tick();
    drv0(2'b00, 32'h0, 32'h0, 4'h0); idle(RL0 - 1);

    // Read+write collision acts as a write only.
    drv0(2'b11, 32'd7, 32'h12345678, 4'hF); exp_wr0(); tick();
    drv0(2'b00, 32'h0, 32'h0, 4'h0); idle(WL0 - 1);
    drv0(2'b01, 32'd7, 32'h0, 4'h0); exp_rd0(32'h12345678); tick();
    drv0(2'b00, 32'h0, 32'h0, 4'h0); idle(RL0 - 1);

    // Read held high only while busy is ignored; re-presented later it works.
    drv0(2'b10, 32'd3, 32'h00000055, 4'hF); exp_wr0(); tick();
    drv0(2'b01, 32'd3, 32'h0, 4'h0); idle(WL0 - 1);
    drv0(2'b00, 32'h0, 32'h0, 4'h0); idle(2);
    drv0(2'b01, 32'd3, 32'h0, 4'h0); exp_rd0(32'h00000055); tick();
    drv0(2'b00, 32'h0, 32'h0, 4'h0); idle(RL0 - 1);
    tick();

    // Reset one cycle into a write: write discarded, done never pulses.
    drv0(2'b10, 32'd9, 32'h0000DEAD, 4'hF);
    bz0_lo = cyc + 1; bz0_hi = cyc + 1;
    tick();
    rst = 1'b1;
    drv0(2'b00, 32'h0, 32'h0, 4'h0);
    tick();
    rst = 1'b0;
    chk("abort_rdata0", rdata0, 32'h0);
    idle(4);
    drv0(2'b01, 32'd9, 32'h0, 4'h0); exp_rd0(32'h0); tick();
    drv0(2'b00, 32'h0, 32'h0, 4'h0); idle(RL0 - 1);

    // Address wrap: word 0x400 aliases word 0.
    drv0(2'b01, 32'h400, 32'h0, 4'h0); exp_rd0(32'h1); tick();
    drv0(2'b00, 32'h0, 32'h0, 4'h0); idle(RL0 - 1);

    // Single-cycle instance: back-to-back requests every cycle, no busy.
    drv1(2'b10, 32'd2, 32'hCAFEF00D, 4'hF); dq1.push_back(cyc + 1); tick();
    drv1(2'b01, 32'd2, 32'h0, 4'h0); rq1.push_back('{32'hCAFEF00D, cyc + 1}); tick();
    drv1(2'b01, 32'd0, 32'h0, 4'h0); rq1.push_back('{32'h00000001, cyc + 1}); tick();
    drv1(2'b10, 32'd2, 32'h11000000, 4'b1000); dq1.push_back(cyc + 1); tick();
    drv1(2'b01, 32'd2, 32'h0, 4'h0); rq1.push_back('{32'h11FEF00D, cyc + 1}); tick();
    drv1(2'b00, 32'h0, 32'h0, 4'h0);
    idle(3);

    chk("rq0_empty", rq0.size(), 32'd0);
    chk("dq0_empty", dq0.size(), 32'd0);
    chk("rq1_empty", rq1.size(), 32'd0);
    chk("dq1_empty", dq1.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
